// File: rtl/port_cmd_issuer.sv
// Command issuer: queues host requests, tags them from a small pool and issues
// one per cycle to a calculator port; matches tagged responses back to the host.
module port_cmd_issuer #(
  parameter int INSTR_WD   = 4,
  parameter int DATA_WD    = 32,
  parameter int RSP_WD     = 2,
  parameter int TAG_WD     = 2,
  parameter int REG_WD     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  // Host side: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready depends only on registered state, never on req_valid.
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [INSTR_WD-1:0] req_op,
  input  logic [REG_WD-1:0]   req_d1,
  input  logic [REG_WD-1:0]   req_d2,
  input  logic [REG_WD-1:0]   req_r1,
  input  logic [DATA_WD-1:0]  req_data,
  output logic [INSTR_WD-1:0] op,
  output logic [REG_WD-1:0]   d1,
  output logic [REG_WD-1:0]   d2,
  output logic [REG_WD-1:0]   r1,
  output logic [DATA_WD-1:0]  data_in,
  output logic [TAG_WD-1:0]   tag_in,
  input  logic [RSP_WD-1:0]   resp,
  input  logic [TAG_WD-1:0]   tag_out,
  input  logic [DATA_WD-1:0]  data_out,
  output logic                rsp_valid,
  output logic [RSP_WD-1:0]   rsp_code,
  output logic [TAG_WD-1:0]   rsp_tag,
  output logic [DATA_WD-1:0]  rsp_data,
  output logic [TAG_WD:0]     outstanding,
  output logic                spurious_err
);

  localparam int NUM_TAGS = 1 << TAG_WD;
  localparam int PTR_WD   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_WD   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_WD = INSTR_WD + 3 * REG_WD + DATA_WD;

  logic [ENTRY_WD-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_WD-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WD-1:0]   count_q, count_d;
  logic [NUM_TAGS-1:0] busy_q, busy_d;

  logic [INSTR_WD-1:0] op_q;
  logic [REG_WD-1:0]   d1_q, d2_q, r1_q;
  logic [DATA_WD-1:0]  data_in_q;
  logic [TAG_WD-1:0]   tag_in_q;
  logic                rsp_valid_q;
  logic [RSP_WD-1:0]   rsp_code_q;
  logic [TAG_WD-1:0]   rsp_tag_q;
  logic [DATA_WD-1:0]  rsp_data_q;
  logic                spurious_err_q;

  logic                push, issue, any_free, rsp_hit, rsp_spur;
  logic [TAG_WD-1:0]   free_tag;
  logic [INSTR_WD-1:0] h_op;
  logic [REG_WD-1:0]   h_d1, h_d2, h_r1;
  logic [DATA_WD-1:0]  h_data;

  function automatic logic [PTR_WD-1:0] next_ptr(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_ready = !reset && (count_q < CNT_WD'(FIFO_DEPTH));
  assign {h_op, h_d1, h_d2, h_r1, h_data} = fifo_mem_q[rd_ptr_q];

  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    // Scan downward so the lowest-numbered free tag wins.
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_tag = TAG_WD'(i);
        any_free = 1'b1;
      end
    end
    push     = req_valid && req_ready && (req_op != '0);
    issue    = (count_q != '0) && any_free;
    rsp_hit  = (resp != '0) && busy_q[tag_out];
    rsp_spur = (resp != '0) && !busy_q[tag_out];
    // Freeing and allocating always touch different tags: only a free tag is issued.
    busy_d = busy_q;
    if (rsp_hit) busy_d[tag_out] = 1'b0;
    if (issue)   busy_d[free_tag] = 1'b1;
    count_d  = count_q + CNT_WD'(push) - CNT_WD'(issue);
    wr_ptr_d = push  ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = issue ? next_ptr(rd_ptr_q) : rd_ptr_q;
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NUM_TAGS; i++) outstanding = outstanding + (TAG_WD + 1)'(busy_q[i]);
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {req_op, req_d1, req_d2, req_r1, req_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      op_q           <= '0;
      d1_q           <= '0;
      d2_q           <= '0;
      r1_q           <= '0;
      data_in_q      <= '0;
      tag_in_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_code_q     <= '0;
      rsp_tag_q      <= '0;
      rsp_data_q     <= '0;
      spurious_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      op_q      <= issue ? h_op     : '0;
      d1_q      <= issue ? h_d1     : '0;
      d2_q      <= issue ? h_d2     : '0;
      r1_q      <= issue ? h_r1     : '0;
      data_in_q <= issue ? h_data   : '0;
      tag_in_q  <= issue ? free_tag : '0;
      rsp_valid_q <= rsp_hit;
      rsp_code_q  <= rsp_hit ? resp     : '0;
      rsp_tag_q   <= rsp_hit ? tag_out  : '0;
      rsp_data_q  <= rsp_hit ? data_out : '0;
      if (rsp_spur) spurious_err_q <= 1'b1;
    end
  end

  assign op           = op_q;
  assign d1           = d1_q;
  assign d2           = d2_q;
  assign r1           = r1_q;
  assign data_in      = data_in_q;
  assign tag_in       = tag_in_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_code     = rsp_code_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_data     = rsp_data_q;
  assign spurious_err = spurious_err_q;

endmodule

// File: tb/tb_port_cmd_issuer.sv
// Directed bench for port_cmd_issuer: expected issues and host responses are
// queued at stimulus time and consumed by a negedge monitor.
module tb_port_cmd_issuer;

  logic        clock, reset, req_valid, req_ready;
  logic [3:0]  req_op, req_d1, req_d2, req_r1;
  logic [31:0] req_data;
  logic [3:0]  op, d1, d2, r1;
  logic [31:0] data_in;
  logic [1:0]  tag_in;
  logic [1:0]  resp, tag_out;
  logic [31:0] data_out;
  logic        rsp_valid;
  logic [1:0]  rsp_code, rsp_tag;
  logic [31:0] rsp_data;
  logic [2:0]  outstanding;
  logic        spurious_err;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [49:0] iss_q[$];
  logic [35:0] rsp_q[$];

  int tag_tbl[9] = '{0, 1, 2, 3, 2, 0, 1, 2, 3};

  port_cmd_issuer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1), .req_data(req_data),
    .op(op), .d1(d1), .d2(d2), .r1(r1), .data_in(data_in), .tag_in(tag_in),
    .resp(resp), .tag_out(tag_out), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .outstanding(outstanding), .spurious_err(spurious_err)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Driver tasks
  task automatic drive_req(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [31:0] dat);
    req_valid = 1'b1; req_op = o; req_d1 = a; req_d2 = b; req_r1 = c; req_data = dat;
    step();
    req_valid = 1'b0; req_op = '0; req_d1 = '0; req_d2 = '0; req_r1 = '0; req_data = '0;
  endtask

  task automatic push_exp_req(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [31:0] dat, input logic [1:0] t);
    iss_q.push_back({o, a, b, c, dat, t});
    drive_req(o, a, b, c, dat);
  endtask

  task automatic respond(input logic [1:0] rc, input logic [1:0] t, input logic [31:0] dat,
                         input bit expect_rsp);
    if (expect_rsp) rsp_q.push_back({rc, t, dat});
    resp = rc; tag_out = t; data_out = dat;
    step();
    resp = '0; tag_out = '0; data_out = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    check("rst_op", op, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_spurious", spurious_err, 0);
    check("rst_req_ready", req_ready, 0);
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", req_ready, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (mon_en) begin
      if (op !== '0) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue: got op=%0h tag=%0h expected no issue at %0t", op, tag_in, $time);
        end else begin
          check("issue", {op, d1, d2, r1, data_in, tag_in}, iss_q.pop_front());
        end
      end else begin
        check("idle_fields", {d1, d2, r1, data_in, tag_in}, 0);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got tag=%0h data=%0h expected no response at %0t", rsp_tag, rsp_data, $time);
        end else begin
          check("rsp", {rsp_code, rsp_tag, rsp_data}, rsp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_d1 = '0; req_d2 = '0; req_r1 = '0;
    req_data = '0; resp = '0; tag_out = '0; data_out = '0;
    do_reset();

    // Basic issue and response
    push_exp_req(4'd1, 4'd2, 4'd3, 4'd4, 32'd0, 2'd0);
    step();
    check("basic_outstanding_1", outstanding, 1);
    respond(2'd1, 2'd0, 32'd5, 1'b1);
    check("basic_outstanding_0", outstanding, 0);
    step(); step();

    // Tag exhaustion: six requests, four tags
    for (int i = 0; i < 6; i++)
      push_exp_req(4'(i + 2), 4'(i), 4'(i + 8), 4'(15 - i), 32'h100 + 32'(i), 2'(tag_tbl[i]));
    check("exhaust_outstanding", outstanding, 4);
    check("exhaust_req_ready", req_ready, 1);
    respond(2'd1, 2'd2, 32'hAA, 1'b1);
    step();
    check("reuse_outstanding", outstanding, 4);

    // Full queue with tags held
    for (int i = 6; i < 9; i++)
      push_exp_req(4'(i + 2), 4'(i), 4'(i + 8), 4'(15 - i), 32'h100 + 32'(i), 2'(tag_tbl[i]));
    check("full_req_ready", req_ready, 0);
    drive_req(4'd15, 4'd15, 4'd15, 4'd15, 32'hDEAD);
    check("full_still_not_ready", req_ready, 0);
    check("full_outstanding", outstanding, 4);
    for (int t = 0; t < 4; t++) respond(2'd3, 2'(t), 32'h200 + 32'(t), 1'b1);
    step(); step();
    check("drain_req_ready", req_ready, 1);
    check("drain_outstanding", outstanding, 4);
    for (int t = 0; t < 4; t++) respond(2'd2, 2'(t), 32'h300 + 32'(t), 1'b1);
    check("drain_done_outstanding", outstanding, 0);
    step(); step(); step();

    // No-op filter
    drive_req(4'd0, 4'd1, 4'd1, 4'd1, 32'h55);
    step(); step(); step();
    check("noop_outstanding", outstanding, 0);
    check("noop_req_ready", req_ready, 1);

    // Spurious response
    respond(2'd2, 2'd3, 32'h77, 1'b0);
    check("spurious_set", spurious_err, 1);
    step(); step(); step();
    check("spurious_sticky", spurious_err, 1);

    // Reset mid-flight
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push_exp_req(4'(i + 9), 4'(i), 4'(i), 4'(i), 32'h400 + 32'(i), 2'(i));
      else       drive_req(4'(i + 9), 4'(i), 4'(i), 4'(i), 32'h400 + 32'(i));
    end
    respond(2'd1, 2'd3, 32'h33, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_outstanding", outstanding, 0);
    check("midrst_spurious", spurious_err, 0);
    check("midrst_op", op, 0);
    step(); step(); step();
    respond(2'd1, 2'd0, 32'h10, 1'b0);
    check("stale_spurious", spurious_err, 1);
    respond(2'd2, 2'd1, 32'h11, 1'b0);
    respond(2'd3, 2'd2, 32'h12, 1'b0);
    check("stale_outstanding", outstanding, 0);
    check("stale_spurious_sticky", spurious_err, 1);
    step(); step(); step();

    check("iss_q_empty", iss_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
